// File: rtl/wb_port_arbiter_pkg.sv
// Core-wide constants shared by the writeback port arbiter and its result buffer.
package wb_port_arbiter_pkg;

    localparam int CORE_XLEN  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering long-latency-unit results ({rd, data}) until
// the register-file write port has a free slot.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = CORE_XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] pushRd,
    input  logic [DW-1:0]         pushData,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [REG_ADDR_W-1:0] headRd,
    output logic [DW-1:0]         headData
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [REG_ADDR_W-1:0] rdMem   [DEPTH];
    logic [DW-1:0]         dataMem [DEPTH];
    logic [AW-1:0]         wrPtr, rdPtr;
    logic [CW-1:0]         count;
    logic                  doPush, doPop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headRd   = rdMem[rdPtr];
    assign headData = dataMem[rdPtr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            rdMem[wrPtr]   <= pushRd;
            dataMem[wrPtr] <= pushData;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs buffered LLU results,
// with a pending-destination scoreboard and an anti-starvation WB freeze.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN         = CORE_XLEN,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_OUT      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_wdata,
    input  logic                  llu_valid,
    input  logic [REG_ADDR_W-1:0] llu_rd,
    input  logic [XLEN-1:0]       llu_data,
    output logic                  llu_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_we,
    output logic                  hazard_stall,
    output logic                  pipe_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic                  fifoFull, fifoEmpty, fifoPush, fifoPop;
    logic [REG_ADDR_W-1:0] headRd;
    logic [XLEN-1:0]       headData;
    logic [NUM_REGS-1:0]   pending, pendNext;
    logic [OUT_W-1:0]      outstanding, outNext;
    logic [STV_W-1:0]      starveCnt;
    logic                  pipeAct, lluAcc, lluDrop, issueAcc;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (XLEN)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushRd   (llu_rd),
        .pushData (llu_data),
        .pop      (fifoPop),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .headRd   (headRd),
        .headData (headData)
    );

    assign pipeAct    = pipe_we && (pipe_rd != '0);
    assign pipe_stall = (starveCnt == STV_W'(STARVE_LIMIT)) && !fifoEmpty;
    // While the WB stage is frozen its write is ignored and the FIFO head drains.
    assign fifoPop    = !fifoEmpty && (pipe_stall || !pipeAct);

    assign llu_ready = !fifoFull;
    assign lluAcc    = llu_valid && !fifoFull;
    assign fifoPush  = lluAcc && (llu_rd != '0);
    assign lluDrop   = lluAcc && (llu_rd == '0);

    assign issue_ready  = !pending[issue_rd] && (outstanding < OUT_W'(MAX_OUT));
    assign issueAcc     = issue_valid && issue_ready;
    assign hazard_stall = pending[dec_rs1] || pending[dec_rs2] || (dec_we && pending[dec_rd]);

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (fifoPop) begin
            rf_we    = 1'b1;
            rf_rd    = headRd;
            rf_wdata = headData;
        end else if (pipeAct) begin
            rf_we    = 1'b1;
            rf_rd    = pipe_rd;
            rf_wdata = pipe_wdata;
        end
    end

    // issue_ready already excludes a pending rd, so set and clear never collide.
    always_comb begin
        pendNext = pending;
        if (fifoPop)  pendNext[headRd]   = 1'b0;
        if (issueAcc) pendNext[issue_rd] = 1'b1;
        pendNext[0] = 1'b0;
    end

    always_comb begin
        outNext = outstanding;
        if (issueAcc) outNext = outNext + OUT_W'(1);
        if (fifoPop)  outNext = outNext - OUT_W'(1);
        if (lluDrop)  outNext = outNext - OUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            outstanding <= '0;
            starveCnt   <= '0;
        end else begin
            pending     <= pendNext;
            outstanding <= outNext;
            if (fifoEmpty || fifoPop)
                starveCnt <= '0;
            else if (starveCnt != STV_W'(STARVE_LIMIT))
                starveCnt <= starveCnt + STV_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model.
module tb_wb_port_arbiter;

    localparam int XLEN         = 32;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_OUT      = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_wdata;
    logic            llu_valid;
    logic [4:0]      llu_rd;
    logic [XLEN-1:0] llu_data;
    logic            llu_ready;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_we;
    logic            hazard_stall, pipe_stall, rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;

    wb_port_arbiter #(
        .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
        .hazard_stall(hazard_stall), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    // Behavioural model: result queue, pending set, op count, blocked-cycle count.
    ent_t       mq[$];
    logic [4:0] inflight[$];
    logic       mPend[32];
    int         mOut, mStarve;

    logic            mPop, expLluReady, expIssueReady, expHaz, expStall;
    logic [37:0]     expRf;
    int total = 0;
    int bad   = 0;

    task automatic model_clear();
        mq.delete();
        inflight.delete();
        for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
        mOut    = 0;
        mStarve = 0;
    endtask

    // Settle combinational outputs and derive what the rules demand this cycle.
    task automatic settle();
        logic act, emp;
        #1;
        emp           = (mq.size() == 0);
        act           = pipe_we && (pipe_rd != 5'd0);
        expStall      = (mStarve >= STARVE_LIMIT) && !emp;
        mPop          = !emp && (expStall || !act);
        if (mPop)     expRf = {1'b1, mq[0].rd, mq[0].data};
        else if (act) expRf = {1'b1, pipe_rd, pipe_wdata};
        else          expRf = '0;
        expLluReady   = (mq.size() < FIFO_DEPTH);
        expIssueReady = !mPend[issue_rd] && (mOut < MAX_OUT);
        expHaz        = mPend[dec_rs1] || mPend[dec_rs2] || (dec_we && mPend[dec_rd]);
    endtask

    // Advance the model across a clock edge using this cycle's decisions.
    task automatic adv();
        logic acc, iss, emp;
        @(posedge clk);
        emp = (mq.size() == 0);
        acc = llu_valid && expLluReady;
        iss = issue_valid && expIssueReady;
        if (rst) begin
            model_clear();
        end else begin
            if (emp || mPop) mStarve = 0;
            else if (mStarve < STARVE_LIMIT) mStarve++;
            if (mPop) begin
                mPend[mq[0].rd] = 1'b0;
                void'(mq.pop_front());
                mOut--;
            end
            if (acc) begin
                if (llu_rd != 5'd0) mq.push_back('{rd: llu_rd, data: llu_data});
                else mOut--;
                void'(inflight.pop_front());
            end
            if (iss) begin
                if (issue_rd != 5'd0) mPend[issue_rd] = 1'b1;
                mOut++;
                inflight.push_back(issue_rd);
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_wdata = '0;
        llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_we = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        settle();
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        dec_rs1 = 5'd5; dec_rs2 = 5'd6; dec_rd = 5'd7; dec_we = 1'b1; issue_rd = 5'd5;
        settle();
        total++;
        if ({rf_we, pipe_stall, hazard_stall, llu_ready, issue_ready} !== 5'b00011) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00011",
                     {rf_we, pipe_stall, hazard_stall, llu_ready, issue_ready});
        end
        adv();
    endtask

    task automatic test_basic();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd5;
        settle();
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL basic_issue_ready got=%b exp=1", issue_ready); end
        adv();
        issue_valid = 1'b0; dec_rs1 = 5'd5;
        settle();
        total++;
        if (hazard_stall !== 1'b1) begin bad++; $display("FAIL basic_pending_set got=%b exp=1", hazard_stall); end
        adv();
        llu_valid = 1'b1; llu_rd = 5'd5; llu_data = 32'hDEADBEEF;
        settle();
        total++;
        if ({rf_we, llu_ready} !== 2'b01) begin bad++; $display("FAIL basic_no_bypass got=%b exp=01", {rf_we, llu_ready}); end
        adv();
        llu_valid = 1'b0;
        settle();
        total++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++; $display("FAIL basic_llu_write got=%h exp=%h", {rf_we, rf_rd, rf_wdata}, {1'b1, 5'd5, 32'hDEADBEEF});
        end
        total++;
        if (hazard_stall !== 1'b1) begin bad++; $display("FAIL basic_stall_during_pop got=%b exp=1", hazard_stall); end
        adv();
        settle();
        total++;
        if ({rf_we, hazard_stall} !== 2'b00) begin bad++; $display("FAIL basic_pending_clear got=%b exp=00", {rf_we, hazard_stall}); end
        adv();
    endtask

    task automatic test_starvation();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        settle(); adv();
        issue_valid = 1'b0; llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h77;
        settle(); adv();
        llu_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h33;
        for (int c = 1; c <= 6; c++) begin
            logic [38:0] want;
            settle();
            if (c == 5) want = {1'b1, 1'b1, 5'd7, 32'h77};
            else        want = {1'b0, 1'b1, 5'd3, 32'h33};
            total++;
            if ({pipe_stall, rf_we, rf_rd, rf_wdata} !== want) begin
                bad++; $display("FAIL starve_cycle%0d got=%h exp=%h", c, {pipe_stall, rf_we, rf_rd, rf_wdata}, want);
            end
            adv();
        end
        idle();
    endtask

    task automatic test_max_out();
        do_reset();
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h33;
        issue_valid = 1'b1; issue_rd = 5'd6;
        settle(); adv();
        issue_rd = 5'd7;
        settle();
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL maxout_second_issue got=%b exp=1", issue_ready); end
        adv();
        issue_rd = 5'd8;
        settle();
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL maxout_third_issue got=%b exp=0", issue_ready); end
        issue_valid = 1'b0; llu_valid = 1'b1; llu_rd = 5'd6; llu_data = 32'h66;
        settle(); adv();
        llu_rd = 5'd7; llu_data = 32'h77;
        settle();
        total++;
        if (llu_ready !== 1'b1) begin bad++; $display("FAIL maxout_accept_second got=%b exp=1", llu_ready); end
        adv();
        llu_valid = 1'b0;
        settle();
        total++;
        if ({llu_ready, rf_rd} !== {1'b0, 5'd3}) begin bad++; $display("FAIL maxout_full got=%h exp=%h", {llu_ready, rf_rd}, {1'b0, 5'd3}); end
        pipe_we = 1'b0;
        settle();
        total++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd6, 32'h66}) begin bad++; $display("FAIL maxout_drain0 got=%h exp=%h", {rf_we, rf_rd, rf_wdata}, {1'b1, 5'd6, 32'h66}); end
        adv();
        settle();
        total++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin bad++; $display("FAIL maxout_drain1 got=%h exp=%h", {rf_we, rf_rd, rf_wdata}, {1'b1, 5'd7, 32'h77}); end
        adv();
        settle();
        total++;
        if ({rf_we, issue_ready} !== 2'b01) begin bad++; $display("FAIL maxout_released got=%b exp=01", {rf_we, issue_ready}); end
        adv();
    endtask

    task automatic test_hazard();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        settle(); adv();
        issue_valid = 1'b0; dec_rs2 = 5'd9;
        settle();
        total++;
        if (hazard_stall !== 1'b1) begin bad++; $display("FAIL hazard_rs2 got=%b exp=1", hazard_stall); end
        llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h99;
        settle(); adv();
        llu_valid = 1'b0;
        settle();
        total++;
        if ({rf_we, rf_rd, hazard_stall} !== {1'b1, 5'd9, 1'b1}) begin bad++; $display("FAIL hazard_pop_cycle got=%h exp=%h", {rf_we, rf_rd, hazard_stall}, {1'b1, 5'd9, 1'b1}); end
        adv();
        settle();
        total++;
        if (hazard_stall !== 1'b0) begin bad++; $display("FAIL hazard_release got=%b exp=0", hazard_stall); end
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0; dec_we = 1'b1;
        settle();
        total++;
        if (hazard_stall !== 1'b0) begin bad++; $display("FAIL hazard_x0 got=%b exp=0", hazard_stall); end
        adv();
    endtask

    task automatic test_x0();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd4;
        settle(); adv();
        issue_valid = 1'b0; llu_valid = 1'b1; llu_rd = 5'd4; llu_data = 32'h44444444;
        settle(); adv();
        llu_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wdata = 32'h1234;
        settle();
        total++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd4, 32'h44444444}) begin bad++; $display("FAIL x0_fifo_wins got=%h exp=%h", {rf_we, rf_rd, rf_wdata}, {1'b1, 5'd4, 32'h44444444}); end
        adv();
        settle();
        total++;
        if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_never_written got=%b exp=0", rf_we); end
        // An x0-destined LLU result is dropped yet still retires its slot.
        pipe_we = 1'b0; issue_valid = 1'b1; issue_rd = 5'd0;
        settle(); adv();
        issue_valid = 1'b0; llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'h5;
        settle(); adv();
        llu_valid = 1'b0;
        settle();
        total++;
        if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_drop_not_pushed got=%b exp=0", rf_we); end
        issue_valid = 1'b1; issue_rd = 5'd12;
        settle(); adv();
        issue_rd = 5'd13;
        settle();
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL x0_drop_retires got=%b exp=1", issue_ready); end
        adv();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h33;
        issue_valid = 1'b1; issue_rd = 5'd10;
        settle(); adv();
        issue_rd = 5'd11;
        settle(); adv();
        issue_valid = 1'b0; llu_valid = 1'b1; llu_rd = 5'd10; llu_data = 32'hA;
        settle(); adv();
        llu_rd = 5'd11; llu_data = 32'hB;
        settle(); adv();
        llu_valid = 1'b0;
        settle(); adv();
        settle(); adv();
        settle();
        total++;
        if ({pipe_stall, llu_ready} !== 2'b00) begin bad++; $display("FAIL midrst_pre got=%b exp=00", {pipe_stall, llu_ready}); end
        rst = 1'b1; pipe_we = 1'b0;
        settle(); adv();
        rst = 1'b0; dec_rs1 = 5'd10; dec_rs2 = 5'd11; issue_rd = 5'd10;
        settle();
        total++;
        if ({rf_we, pipe_stall, hazard_stall, llu_ready, issue_ready} !== 5'b00011) begin
            bad++; $display("FAIL midrst_post got=%b exp=00011", {rf_we, pipe_stall, hazard_stall, llu_ready, issue_ready});
        end
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            pipe_we     = $urandom_range(0, 2) != 0;
            pipe_rd     = 5'($urandom_range(0, 7));
            pipe_wdata  = $urandom;
            issue_valid = $urandom_range(0, 1) != 0;
            issue_rd    = 5'($urandom_range(0, 9));
            llu_valid   = (inflight.size() != 0) && ($urandom_range(0, 2) != 0);
            llu_rd      = (inflight.size() != 0) ? inflight[0] : 5'd0;
            llu_data    = $urandom;
            dec_rs1     = 5'($urandom_range(0, 9));
            dec_rs2     = 5'($urandom_range(0, 9));
            dec_rd      = 5'($urandom_range(0, 9));
            dec_we      = $urandom_range(0, 1) != 0;
            settle();
            total++;
            if ({rf_we, rf_rd, rf_wdata} !== expRf) begin
                bad++; $display("FAIL rand_rf c=%0d got=%h exp=%h", c, {rf_we, rf_rd, rf_wdata}, expRf);
            end
            total++;
            if ({llu_ready, issue_ready, hazard_stall, pipe_stall} !== {expLluReady, expIssueReady, expHaz, expStall}) begin
                bad++; $display("FAIL rand_ctl c=%0d got=%b exp=%b", c,
                    {llu_ready, issue_ready, hazard_stall, pipe_stall}, {expLluReady, expIssueReady, expHaz, expStall});
            end
            adv();
        end
        idle();
    endtask

    initial begin
        model_clear();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_starvation();
        test_max_out();
        test_hazard();
        test_x0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
